// File: rtl/bcd2bin_arb_pkg.sv
// Shared types and constants for the bcd2bin round-robin arbiter.
// ERR state is reachable only when BCD2BIN_ARB_DIGIT_CHECK_EN is defined.
package bcd2bin_arb_pkg;

  localparam int BCD_W       = 4;
  localparam int BIN_W       = 7;
  localparam int NUM_REQ_MAX = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ERR   = 2'd3
  } arb_state_e;

  function automatic logic bcd_digit_bad(input logic [BCD_W-1:0] d);
    return d > BCD_W'(9);
  endfunction

endpackage

// File: rtl/bcd2bin_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after rr_ptr,
// wrapping from N-1 back to 0.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any_grant
);

  logic [IW-1:0] cand_idx [N];

  // cand_idx[k] is the requester examined at priority position k
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_cand
      logic [IW:0] sum;
      assign sum          = {1'b0, rr_ptr} + (IW+1)'(gi);
      assign cand_idx[gi] = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : IW'(sum);
    end
  endgenerate

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any_grant && req[cand_idx[k]]) begin
        any_grant           = 1'b1;
        grant_idx           = cand_idx[k];
        grant[cand_idx[k]]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bcd2bin_arbiter.sv
// Shares one bcd2bin converter among NUM_REQ requesters, one transaction at a time.
// Define BCD2BIN_ARB_DIGIT_CHECK_EN to reject digits above 9 with an rsp_err response.
module bcd2bin_arbiter
  import bcd2bin_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int OWN_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [BCD_W*NUM_REQ-1:0] req_bcd1,
  input  logic [BCD_W*NUM_REQ-1:0] req_bcd0,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [BIN_W-1:0]         rsp_bin,
  output logic                     rsp_err,
  output logic                     busy,
  output logic                     cvt_start,
  output logic [BCD_W-1:0]         cvt_bcd1,
  output logic [BCD_W-1:0]         cvt_bcd0,
  input  logic                     cvt_ready,
  input  logic                     cvt_done_tick,
  input  logic [BIN_W-1:0]         cvt_bin
);

  arb_state_e           state_q, state_d;
  logic [OWN_W-1:0]     owner_q, owner_d;
  logic [OWN_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [BCD_W-1:0]     cvt_bcd1_q, cvt_bcd1_d;
  logic [BCD_W-1:0]     cvt_bcd0_q, cvt_bcd0_d;
  logic                 cvt_start_q, cvt_start_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [BIN_W-1:0]     rsp_bin_q, rsp_bin_d;
  logic                 busy_q, busy_d;
`ifdef BCD2BIN_ARB_DIGIT_CHECK_EN
  logic                 rsp_err_q, rsp_err_d;
`endif

  logic [NUM_REQ-1:0]   gnt_oh;
  logic [OWN_W-1:0]     gnt_idx;
  logic                 gnt_any;
  logic                 accept;
  logic [OWN_W-1:0]     ptr_after_owner;
  logic [BCD_W-1:0]     bcd1_arr [NUM_REQ];
  logic [BCD_W-1:0]     bcd0_arr [NUM_REQ];
  logic [BCD_W-1:0]     sel_bcd1, sel_bcd0;

  rr_arbiter #(.N(NUM_REQ), .IW(OWN_W)) u_rr (
    .req       (req_valid),
    .rr_ptr    (rr_ptr_q),
    .grant     (gnt_oh),
    .grant_idx (gnt_idx),
    .any_grant (gnt_any)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_digits
      assign bcd1_arr[gi] = req_bcd1[BCD_W*gi +: BCD_W];
      assign bcd0_arr[gi] = req_bcd0[BCD_W*gi +: BCD_W];
    end
  endgenerate

  assign sel_bcd1 = bcd1_arr[gnt_idx];
  assign sel_bcd0 = bcd0_arr[gnt_idx];

  // reset_n gating keeps the combinational accept pulse quiet while held in reset
  assign accept    = reset_n && (state_q == IDLE) && cvt_ready && gnt_any;
  assign req_ready = accept ? gnt_oh : '0;

  assign ptr_after_owner = (owner_q == OWN_W'(NUM_REQ-1)) ? '0 : owner_q + OWN_W'(1);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    cvt_bcd1_d  = cvt_bcd1_q;
    cvt_bcd0_d  = cvt_bcd0_q;
    cvt_start_d = 1'b0;
    rsp_valid_d = '0;
    rsp_bin_d   = rsp_bin_q;
`ifdef BCD2BIN_ARB_DIGIT_CHECK_EN
    rsp_err_d   = rsp_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          owner_d = gnt_idx;
`ifdef BCD2BIN_ARB_DIGIT_CHECK_EN
          if (bcd_digit_bad(sel_bcd1) || bcd_digit_bad(sel_bcd0)) begin
            state_d = ERR;
          end else begin
            cvt_bcd1_d  = sel_bcd1;
            cvt_bcd0_d  = sel_bcd0;
            cvt_start_d = 1'b1;
            state_d     = ISSUE;
          end
`else
          cvt_bcd1_d  = sel_bcd1;
          cvt_bcd0_d  = sel_bcd0;
          cvt_start_d = 1'b1;
          state_d     = ISSUE;
`endif
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (cvt_done_tick) begin
          rsp_bin_d            = cvt_bin;
          rsp_valid_d[owner_q] = 1'b1;
          rr_ptr_d             = ptr_after_owner;
          state_d              = IDLE;
`ifdef BCD2BIN_ARB_DIGIT_CHECK_EN
          rsp_err_d            = 1'b0;
`endif
        end
      end
`ifdef BCD2BIN_ARB_DIGIT_CHECK_EN
      ERR: begin
        rsp_bin_d            = '0;
        rsp_err_d            = 1'b1;
        rsp_valid_d[owner_q] = 1'b1;
        rr_ptr_d             = ptr_after_owner;
        state_d              = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      cvt_bcd1_q  <= '0;
      cvt_bcd0_q  <= '0;
      cvt_start_q <= 1'b0;
      rsp_valid_q <= '0;
      rsp_bin_q   <= '0;
      busy_q      <= 1'b0;
`ifdef BCD2BIN_ARB_DIGIT_CHECK_EN
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      cvt_bcd1_q  <= cvt_bcd1_d;
      cvt_bcd0_q  <= cvt_bcd0_d;
      cvt_start_q <= cvt_start_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_bin_q   <= rsp_bin_d;
      busy_q      <= busy_d;
`ifdef BCD2BIN_ARB_DIGIT_CHECK_EN
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_bin   = rsp_bin_q;
  assign busy      = busy_q;
  assign cvt_start = cvt_start_q;
  assign cvt_bcd1  = cvt_bcd1_q;
  assign cvt_bcd0  = cvt_bcd0_q;
`ifdef BCD2BIN_ARB_DIGIT_CHECK_EN
  assign rsp_err   = rsp_err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_bcd2bin_arbiter.sv
// Bench for bcd2bin_arbiter: timeline reference model plus an emulated converter
// with variable latency; digit-check cases run when BCD2BIN_ARB_DIGIT_CHECK_EN is defined.
module tb_bcd2bin_arbiter;

  localparam int N   = 4;
  localparam int CAP = 128;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N-1:0]   req_valid;
  logic [4*N-1:0] req_bcd1, req_bcd0;
  logic [N-1:0]   req_ready, rsp_valid;
  logic [6:0]     rsp_bin;
  logic           rsp_err, busy, cvt_start;
  logic [3:0]     cvt_bcd1, cvt_bcd0;
  logic           cvt_ready, cvt_done_tick;
  logic [6:0]     cvt_bin;

  always #5 clk = ~clk;

  bcd2bin_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_bcd1(req_bcd1), .req_bcd0(req_bcd0),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_bin(rsp_bin), .rsp_err(rsp_err),
    .busy(busy), .cvt_start(cvt_start), .cvt_bcd1(cvt_bcd1), .cvt_bcd0(cvt_bcd0),
    .cvt_ready(cvt_ready), .cvt_done_tick(cvt_done_tick), .cvt_bin(cvt_bin)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // per-requester request FIFOs (pending digits)
  int f1 [N][CAP];
  int f0 [N][CAP];
  int hd [N];
  int tl [N];

  // transaction timeline model
  int cyc = 0;
  int rr_m = 0;
  bit m_busy = 0;
  bit m_err = 0;
  int m_owner, m_d1, m_d0;
  int exp_start = -1;
  int exp_rsp = -1;
  int last_t0 = -1;

  // emulated converter
  bit conv_busy = 0;
  int done_cyc = -1;
  int conv_a, conv_b;
  int lat_cfg = 2;
  bit lat_rand = 0;
  bit spur_en = 0;
  bit rand_drop = 0;
  int hold_low = 0;

  int glog[$];
  int blog[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit dig_err(input int a, input int b);
`ifdef BCD2BIN_ARB_DIGIT_CHECK_EN
    return (a > 9) || (b > 9);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit pending_any();
    for (int i = 0; i < N; i++) if (hd[i] < tl[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic push(input int r, input int a, input int b);
    if (tl[r] < CAP) begin
      f1[r][tl[r]] = a;
      f0[r][tl[r]] = b;
      tl[r]++;
    end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      if (hd[i] < tl[i]) begin
        req_valid[i]     = 1'b1;
        req_bcd1[4*i +: 4] = 4'(f1[i][hd[i]]);
        req_bcd0[4*i +: 4] = 4'(f0[i][hd[i]]);
      end else begin
        req_valid[i]     = 1'b0;
        req_bcd1[4*i +: 4] = 4'($urandom_range(0, 15));
        req_bcd0[4*i +: 4] = 4'($urandom_range(0, 15));
      end
    end
  endtask

  // One clock cycle: check registered outputs, run the converter, present requests, check grant.
  task automatic tick();
    int exp_g;
    int lat;
    int j;
    @(posedge clk);
    #1;
    cyc++;
    if (m_busy && cyc == exp_rsp) begin
      check("rsp_valid", 32'(rsp_valid), 32'(1 << m_owner));
      check("rsp_bin", 32'(rsp_bin), m_err ? 32'd0 : 32'(m_d1 * 10 + m_d0));
      check("rsp_err", 32'(rsp_err), 32'(m_err));
      $display("txn req%0d bcd={%0d,%0d} -> bin=0x%02h err=%0d cycle=%0d",
               m_owner, m_d1, m_d0, rsp_bin, rsp_err, cyc);
      blog.push_back(int'(rsp_bin));
      rr_m   = (m_owner + 1) % N;
      m_busy = 1'b0;
    end else begin
      check("rsp_valid_quiet", 32'(rsp_valid), 32'd0);
    end
    check("cvt_start", 32'(cvt_start), 32'(m_busy && cyc == exp_start));
    check("busy", 32'(busy), 32'(m_busy));
    if (m_busy && !m_err) begin
      check("cvt_bcd1", 32'(cvt_bcd1), 32'(m_d1));
      check("cvt_bcd0", 32'(cvt_bcd0), 32'(m_d0));
    end

    cvt_done_tick = 1'b0;
    if (conv_busy && cyc > done_cyc) conv_busy = 1'b0;
    if (m_busy && cyc == exp_start) begin
      lat       = lat_rand ? int'($urandom_range(1, 4)) : lat_cfg;
      conv_busy = 1'b1;
      done_cyc  = cyc + lat;
      exp_rsp   = done_cyc + 1;
      conv_a    = int'(cvt_bcd1);
      conv_b    = int'(cvt_bcd0);
    end
    if (conv_busy && cyc == done_cyc) begin
      cvt_done_tick = 1'b1;
      cvt_bin       = 7'(conv_a * 10 + conv_b);
    end else if (spur_en && (!m_busy || cyc == exp_start) && $urandom_range(0, 3) == 0) begin
      cvt_done_tick = 1'b1;
      cvt_bin       = 7'($urandom_range(0, 127));
    end

    if (rand_drop && hold_low == 0 && $urandom_range(0, 7) == 0) hold_low = int'($urandom_range(1, 3));
    cvt_ready = !conv_busy && (hold_low == 0);
    if (hold_low > 0) hold_low--;

    drive_reqs();
    #1;
    exp_g = -1;
    if (!m_busy && cvt_ready) begin
      for (int k = 0; k < N; k++) begin
        j = (rr_m + k) % N;
        if (exp_g < 0 && hd[j] < tl[j]) exp_g = j;
      end
    end
    check("req_ready", 32'(req_ready), (exp_g >= 0) ? 32'(1 << exp_g) : 32'd0);
    if (exp_g >= 0) begin
      m_busy  = 1'b1;
      m_owner = exp_g;
      m_d1    = f1[exp_g][hd[exp_g]];
      m_d0    = f0[exp_g][hd[exp_g]];
      hd[exp_g]++;
      m_err   = dig_err(m_d1, m_d0);
      last_t0 = cyc;
      glog.push_back(exp_g);
      if (m_err) begin
        exp_start = -1;
        exp_rsp   = cyc + 2;
      end else begin
        exp_start = cyc + 1;
        exp_rsp   = -1;
      end
    end
  endtask

  task automatic run_idle(input int max_cycles);
    int n;
    n = 0;
    while ((pending_any() || m_busy) && n < max_cycles) begin
      tick();
      n++;
    end
    check("drain_within_budget", 32'(pending_any() || m_busy), 32'd0);
    tick();
    tick();
  endtask

  task automatic do_reset(input int hold);
    reset_n = 1'b0;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_bin", 32'(rsp_bin), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cvt_start", 32'(cvt_start), 32'd0);
    check("rst_cvt_bcd1", 32'(cvt_bcd1), 32'd0);
    check("rst_cvt_bcd0", 32'(cvt_bcd0), 32'd0);
    m_busy        = 1'b0;
    rr_m          = 0;
    conv_busy     = 1'b0;
    exp_start     = -1;
    exp_rsp       = -1;
    hold_low      = 0;
    cvt_done_tick = 1'b0;
    cvt_ready     = 1'b1;
    repeat (hold) begin
      @(posedge clk);
      #1;
      cyc++;
      check("rst_hold_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_hold_busy", 32'(busy), 32'd0);
    end
    reset_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    int rel;
    int a, b, r;
    reset_n       = 1'b1;
    req_valid     = '0;
    req_bcd1      = '0;
    req_bcd0      = '0;
    cvt_ready     = 1'b1;
    cvt_done_tick = 1'b0;
    cvt_bin       = '0;
    for (int i = 0; i < N; i++) begin
      hd[i] = 0;
      tl[i] = 0;
    end
    #2;
    do_reset(3);

    // single request {9,9}
    lat_cfg = 2;
    push(0, 9, 9);
    run_idle(50);
    check("single_bin", 32'(blog[$]), 32'h63);
    check("single_owner", 32'(glog[$]), 32'd0);

    // chained request held across its own response
    lat_cfg = 1;
    push(0, 1, 2);
    push(0, 4, 7);
    run_idle(50);

    // all four at once from rr_ptr = 0
    do_reset(2);
    glog.delete();
    blog.delete();
    push(0, 0, 0);
    push(1, 5, 5);
    push(2, 0, 9);
    push(3, 9, 0);
    run_idle(100);
    check("all4_count", 32'(glog.size()), 32'd4);
    for (int i = 0; i < 4; i++) check("all4_grant_order", 32'(glog[i]), 32'(i));
    check("all4_bin0", 32'(blog[0]), 32'h00);
    check("all4_bin1", 32'(blog[1]), 32'h37);
    check("all4_bin2", 32'(blog[2]), 32'h09);
    check("all4_bin3", 32'(blog[3]), 32'h5A);

    // wrap-around: serve req2 so rr_ptr becomes 3, then req1 and req3 together
    do_reset(2);
    push(2, 1, 1);
    run_idle(50);
    glog.delete();
    push(1, 2, 2);
    push(3, 3, 3);
    run_idle(100);
    check("wrap_count", 32'(glog.size()), 32'd2);
    check("wrap_first", 32'(glog[0]), 32'd3);
    check("wrap_second", 32'(glog[1]), 32'd1);

    // cvt_ready low for 5 cycles
    lat_cfg  = 3;
    hold_low = 5;
    rel      = cyc;
    push(2, 4, 2);
    run_idle(50);
    check("ready_hold_grant_cycle", 32'(last_t0), 32'(rel + 6));

    // reset while waiting on the converter
    lat_cfg = 6;
    push(0, 3, 4);
    nb = blog.size();
    for (int k = 0; k < 20; k++) begin
      if (m_busy && exp_start > 0 && cyc == exp_start + 2) break;
      tick();
    end
    check("reached_wait", 32'(m_busy && cyc == exp_start + 2), 32'd1);
    do_reset(2);
    repeat (10) tick();
    check("reset_no_rsp", 32'(blog.size()), 32'(nb));
    glog.delete();
    lat_cfg = 2;
    push(2, 6, 1);
    push(1, 8, 8);
    run_idle(100);
    check("post_reset_first", 32'(glog[0]), 32'd1);

`ifdef BCD2BIN_ARB_DIGIT_CHECK_EN
    // invalid tens digit is answered with rsp_err and no converter start
    blog.delete();
    push(1, 10, 3);
    rel = cyc;
    run_idle(20);
    check("err_bin", 32'(blog[$]), 32'd0);
    push(2, 7, 15);
    push(3, 2, 5);
    run_idle(50);
`endif

    // randomized traffic with latency jitter, ready drops and stray done ticks
    lat_rand  = 1'b1;
    spur_en   = 1'b1;
    rand_drop = 1'b1;
    for (int t = 0; t < 40; t++) begin
      r = int'($urandom_range(0, N - 1));
      a = int'($urandom_range(0, 9));
      b = int'($urandom_range(0, 9));
`ifdef BCD2BIN_ARB_DIGIT_CHECK_EN
      if ($urandom_range(0, 7) == 0) a = int'($urandom_range(10, 15));
      if ($urandom_range(0, 7) == 0) b = int'($urandom_range(10, 15));
`endif
      push(r, a, b);
      repeat ($urandom_range(0, 3)) tick();
    end
    run_idle(3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd2bin_arbiter.md
# bcd2bin_arbiter

Round-robin scheduler that shares one `bcd2bin` converter among `NUM_REQ` independent requesters. It accepts two-digit BCD requests, issues each to the converter with a single-cycle `start`, and waits for `done_tick`. It then returns the 7-bit binary result to the requester that owns the transaction. It sits between client logic (test hosts, display/decode front-ends) and a single converter instance.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `OWN_W`, `$clog2(NUM_REQ)`: owner index width (derived, not overridden).
- `clk` in 1: the single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in NUM_REQ: per-requester request pending; held until accepted.
- `req_bcd1` in 4×NUM_REQ: tens digit, packed, requester i at [4i+3:4i].
- `req_bcd0` in 4×NUM_REQ: units digit, same packing.
- `req_ready` out NUM_REQ: one-hot accept pulse.
- `rsp_valid` out NUM_REQ: one-hot single-cycle result pulse; no backpressure.
- `rsp_bin` out 7: result; valid only while any `rsp_valid` bit is set.
- `rsp_err` out 1: invalid-digit flag, qualified by `rsp_valid` (see Configuration).
- `busy` out 1: transaction in flight (state ≠ IDLE).
- `cvt_start` out 1: converter start.
- `cvt_bcd1`, `cvt_bcd0` out 4 each: converter operands, registered.
- `cvt_ready` in 1: converter idle.
- `cvt_done_tick` in 1: converter completion pulse.
- `cvt_bin` in 7: converter result.

## Operation
- FSM states:
  - IDLE: if `cvt_ready` and any `req_valid`, grant the first valid requester at or after `rr_ptr` (wrapping), drive `req_ready[g]`=1 combinationally, latch the digits into `cvt_bcd1/0`, latch `g` into `owner`, then go to ISSUE.
  - ISSUE: `cvt_start`=1 for exactly this cycle, then go to WAIT.
  - WAIT: on `cvt_done_tick`, register `cvt_bin` into `rsp_bin`, set `rsp_valid[owner]` for the next cycle, set `rr_ptr` = `owner`+1 mod NUM_REQ, then go to IDLE.
- Only one transaction is in flight at a time. Operands stay stable from ISSUE until WAIT exits.
- `cvt_done_tick` in IDLE or ISSUE is ignored.
- `req_valid` deasserted before grant has no effect. A requester may hold `req_valid` across its own response to chain a new request.
- If `cvt_ready` is low in IDLE, no grant is made and `rr_ptr` is unchanged.
- `rr_ptr` wraps from NUM_REQ-1 to 0.

## Timing
- Reset values: all outputs 0 (`req_ready`, `rsp_valid`, `rsp_bin`, `rsp_err`, `busy`, `cvt_start`, `cvt_bcd1/0`); `rr_ptr`=0; `owner`=0; state IDLE.
- Reset mid-transaction aborts it; no response is generated.
- Accept cycle is T0, `cvt_start` is T0+1, `done_tick` is T0+1+L, `rsp_valid` is T0+2+L (L = converter latency).
- The earliest next accept is the `rsp_valid` cycle, when the FSM is already in IDLE.
- A `rsp_valid` pulse and a `req_ready` pulse may coincide in the same cycle, for the same or different requesters.

## Configuration
- `BCD2BIN_ARB_DIGIT_CHECK_EN` defined:
  - In IDLE, a granted request with either digit > 9 is consumed but not issued to the converter.
  - FSM goes to an extra state ERR for one cycle.
  - The next cycle gives `rsp_valid[g]`=1, `rsp_err`=1, `rsp_bin`=0, and `rr_ptr` advances as normal.
  - Latency is T0+2.
- Not defined: digits pass to the converter unchecked, the ERR state is absent, and `rsp_err` is tied to 0.

## Structure
- Package `bcd2bin_arb_pkg`:
  - FSM state enum (IDLE, ISSUE, WAIT, ERR).
  - Constants `BCD_W`=4, `BIN_W`=7, `NUM_REQ_MAX`=8.
- Sub-module `rr_arbiter`: combinational round-robin pick.
  - Inputs: request vector, `rr_ptr`.
  - Outputs: one-hot grant, encoded index, any-grant.
- The top module holds the FSM, operand/result registers and `rr_ptr`.

## Test plan
- Single request: req0 = {9,9} → `cvt_start` one cycle after accept; `rsp_valid[0]` with `rsp_bin`=0x63 one cycle after `done_tick`.
- All four requesters valid at once, digits {0,0}, {5,5}, {0,9}, {9,0} → grants in order 0,1,2,3 with results 0x00, 0x37, 0x09, 0x5A; each `rsp_valid` goes only to its owner.
- `rr_ptr`=3 with req1 and req3 valid → req3 granted first, then req1 (wrap-around).
- `cvt_ready` held low for 5 cycles with req2 valid → no `req_ready`; grant on the first cycle `cvt_ready`=1.
- `reset_n` pulsed low during WAIT → all outputs 0 immediately; no `rsp_valid`; the next request is served normally from `rr_ptr`=0.
- With `BCD2BIN_ARB_DIGIT_CHECK_EN`, req1 = {10,3} → `cvt_start` never asserts; `rsp_valid[1]`, `rsp_err`=1, `rsp_bin`=0 at T0+2.
